// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES burst controller: FSM state encoding,
// AHB direction constants and the timer width calculation.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHG_KEY   = 3'd1,
        READ      = 3'd2,
        INIT_WAIT = 3'd3,
        PRE_WAIT  = 3'd4,
        WAIT_AES  = 3'd5,
        WRITE     = 3'd6,
        POST_WAIT = 3'd7
    } state_t;

    localparam logic AHB_RD = 1'b0;
    localparam logic AHB_WR = 1'b1;

    // Width needed to hold the largest timed-state length
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/aes_burst_ctrl_if.sv
// Handshake/status bundle between the AHB side, GenKey/AESctr and the burst
// controller. The error flag exists only when AES_BURST_CTRL_TIMEOUT_EN is
// defined.
interface aes_burst_ctrl_if #(
    parameter int BCNT_W = 8
);
    logic              start;
    logic              change_key;
    logic              decrypt;
    logic [BCNT_W-1:0] num_blocks;
    logic              chg_key_done;
    logic              enc_done;

    logic              change_key_start;
    logic              aes_enable;
    logic              aes_decrypt;
    logic              ahb_mode;
    logic              ahb_shift_en;
    logic              restart_check;
    logic              busy;
    logic              done;
    logic [BCNT_W-1:0] blk_idx;
`ifdef AES_BURST_CTRL_TIMEOUT_EN
    logic              error;
`endif

    // Command/handshake source (AHB slave, GenKey, AESctr side)
    modport master (
        output start, change_key, decrypt, num_blocks, chg_key_done, enc_done,
`ifdef AES_BURST_CTRL_TIMEOUT_EN
        input  error,
`endif
        input  change_key_start, aes_enable, aes_decrypt, ahb_mode,
               ahb_shift_en, restart_check, busy, done, blk_idx
    );

    // Controller side
    modport slave (
        input  start, change_key, decrypt, num_blocks, chg_key_done, enc_done,
`ifdef AES_BURST_CTRL_TIMEOUT_EN
        output error,
`endif
        output change_key_start, aes_enable, aes_decrypt, ahb_mode,
               ahb_shift_en, restart_check, busy, done, blk_idx
    );

endinterface

// File: rtl/aes_ctrl_timer.sv
// Clearable up-counter shared by every timed state of the burst controller.
// tc is high while the count equals the runtime terminal value.
module aes_ctrl_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Count up while enabled; clear has priority so each state starts at zero
    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/aes_burst_ctrl.sv
// AES burst controller: sequences key change, AHB read/write word shifting
// and AES core enable for a burst of num_blocks 128-bit blocks.
// Optional macro AES_BURST_CTRL_TIMEOUT_EN adds a WAIT_AES watchdog and the
// sticky error flag.
module aes_burst_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int BLK_WORDS     = 4,
    parameter int INIT_WAIT_CYC = 10,
    parameter int PRE_WAIT_CYC  = 2,
    parameter int POST_WAIT_CYC = 7,
    parameter int BCNT_W        = 8,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    aes_burst_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(BLK_WORDS, INIT_WAIT_CYC, PRE_WAIT_CYC,
                                     POST_WAIT_CYC, TIMEOUT_CYC);

    // Terminal counts are length-1 because the counter starts at 0 on entry
    localparam logic [CNT_W-1:0] T_BLK  = CNT_W'(BLK_WORDS - 1);
    localparam logic [CNT_W-1:0] T_INIT = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] T_PRE  = CNT_W'(PRE_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] T_POST = CNT_W'(POST_WAIT_CYC - 1);
`ifdef AES_BURST_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] T_TMO  = CNT_W'(TIMEOUT_CYC - 1);
`endif

    state_t            state;
    state_t            state_nx;
    logic              done_q;
    logic              done_nx;
    logic              dec_q;
    logic [BCNT_W-1:0] nblk_q;
    logic [BCNT_W-1:0] blk_idx_q;
    logic              accept;
    logic              burst_go;
    logic              last_blk;
    logic              next_blk;
    logic              timeout_hit;
    logic              tmr_en;
    logic              tmr_clr;
    logic              tmr_tc;
    logic [CNT_W-1:0]  tmr_term;

    assign accept   = (state == IDLE) && bus.start;
    assign burst_go = accept && !bus.change_key && (bus.num_blocks != '0);
    assign last_blk = (blk_idx_q == nblk_q - BCNT_W'(1));
    assign next_blk = (state == POST_WAIT) && tmr_tc && !last_blk;
    assign tmr_clr  = (state_nx != state);

    // Select the running length of the current timed state
    always_comb begin
        tmr_en   = 1'b1;
        tmr_term = '0;
        case (state)
            READ, WRITE: tmr_term = T_BLK;
            INIT_WAIT:   tmr_term = T_INIT;
            PRE_WAIT:    tmr_term = T_PRE;
            POST_WAIT:   tmr_term = T_POST;
`ifdef AES_BURST_CTRL_TIMEOUT_EN
            WAIT_AES:    tmr_term = T_TMO;
`endif
            default:     tmr_en   = 1'b0;
        endcase
    end

    aes_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .tc    (tmr_tc)
    );

    // Next-state logic; done_nx marks a command completing on this edge
    always_comb begin
        state_nx    = state;
        done_nx     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.change_key)            state_nx = CHG_KEY;
                    else if (bus.num_blocks == '0) done_nx  = 1'b1;
                    else                           state_nx = READ;
                end
            end
            CHG_KEY: begin
                if (bus.chg_key_done) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            READ: begin
                if (tmr_tc) state_nx = (blk_idx_q == '0) ? INIT_WAIT : PRE_WAIT;
            end
            INIT_WAIT: begin
                if (tmr_tc) state_nx = PRE_WAIT;
            end
            PRE_WAIT: begin
                if (tmr_tc) state_nx = WAIT_AES;
            end
            WAIT_AES: begin
                if (bus.enc_done) begin
                    state_nx = WRITE;
                end
`ifdef AES_BURST_CTRL_TIMEOUT_EN
                else if (tmr_tc) begin
                    state_nx    = IDLE;
                    done_nx     = 1'b1;
                    timeout_hit = 1'b1;
                end
`endif
            end
            WRITE: begin
                if (tmr_tc) state_nx = POST_WAIT;
            end
            POST_WAIT: begin
                if (tmr_tc) begin
                    if (last_blk) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and registered completion pulse
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
        end
    end

    // Burst context: mode and block count latched at start, block index stepping
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            dec_q     <= 1'b0;
            nblk_q    <= '0;
            blk_idx_q <= '0;
        end else if (burst_go) begin
            dec_q     <= bus.decrypt;
            nblk_q    <= bus.num_blocks;
            blk_idx_q <= '0;
        end else if (next_blk) begin
            blk_idx_q <= blk_idx_q + BCNT_W'(1);
        end
    end

`ifdef AES_BURST_CTRL_TIMEOUT_EN
    logic err_q;

    // Sticky watchdog flag, cleared by the next accepted command
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.error = err_q;
`endif

    assign bus.restart_check    = (state == IDLE);
    assign bus.busy             = (state != IDLE);
    assign bus.change_key_start = (state == CHG_KEY);
    assign bus.aes_enable       = (state == PRE_WAIT) || (state == WAIT_AES);
    assign bus.ahb_mode         = (state == WRITE) ? AHB_WR : AHB_RD;
    assign bus.ahb_shift_en     = (state == READ) || (state == WRITE);
    assign bus.done             = done_q;
    assign bus.aes_decrypt      = dec_q;
    assign bus.blk_idx          = blk_idx_q;

endmodule

// File: tb/tb_aes_burst_ctrl.sv
// Testbench for aes_burst_ctrl: a cycle-schedule model built from the
// command rules drives a per-cycle output compare, plus hand-computed
// literal checks on key points and event counts.
module tb_aes_burst_ctrl;

    localparam int BLK_WORDS     = 4;
    localparam int INIT_WAIT_CYC = 10;
    localparam int PRE_WAIT_CYC  = 2;
    localparam int POST_WAIT_CYC = 7;
    localparam int BCNT_W        = 8;
    localparam int TIMEOUT_CYC   = 64;

    localparam logic [2:0] K_IDLE = 3'd0;
    localparam logic [2:0] K_CHG  = 3'd1;
    localparam logic [2:0] K_RD   = 3'd2;
    localparam logic [2:0] K_GAP  = 3'd3;
    localparam logic [2:0] K_EN   = 3'd4;
    localparam logic [2:0] K_WAIT = 3'd5;
    localparam logic [2:0] K_WR   = 3'd6;

    typedef struct packed {
        logic              rc;
        logic              busy;
        logic              cks;
        logic              en;
        logic              mode;
        logic              shift;
        logic              done;
        logic              dec;
        logic [BCNT_W-1:0] blk;
    } outs_t;

    typedef struct packed {
        logic [2:0] kind;
        outs_t      o;
    } ent_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    aes_burst_ctrl_if #(.BCNT_W(BCNT_W)) bus ();

    aes_burst_ctrl #(
        .BLK_WORDS     (BLK_WORDS),
        .INIT_WAIT_CYC (INIT_WAIT_CYC),
        .PRE_WAIT_CYC  (PRE_WAIT_CYC),
        .POST_WAIT_CYC (POST_WAIT_CYC),
        .BCNT_W        (BCNT_W),
        .TIMEOUT_CYC   (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- model ----------------
    ent_t              q[$];
    ent_t              cur;
    int                m_n;
    int                wait_cnt;
    logic              m_err;
    logic              m_dec;
    logic [BCNT_W-1:0] m_blk;
    bit                chk_en = 0;

    function automatic ent_t mk(input logic [2:0] k, input logic [BCNT_W-1:0] b,
                                input logic d, input logic dn);
        ent_t e;
        e.kind    = k;
        e.o.rc    = (k == K_IDLE);
        e.o.busy  = (k != K_IDLE);
        e.o.cks   = (k == K_CHG);
        e.o.en    = (k == K_EN) || (k == K_WAIT);
        e.o.mode  = (k == K_WR);
        e.o.shift = (k == K_RD) || (k == K_WR);
        e.o.done  = dn;
        e.o.dec   = d;
        e.o.blk   = b;
        return e;
    endfunction

    function automatic void sched_block(input logic [BCNT_W-1:0] b);
        for (int i = 0; i < BLK_WORDS; i++) q.push_back(mk(K_RD, b, m_dec, 1'b0));
        if (b == '0)
            for (int i = 0; i < INIT_WAIT_CYC; i++) q.push_back(mk(K_GAP, b, m_dec, 1'b0));
        for (int i = 0; i < PRE_WAIT_CYC; i++) q.push_back(mk(K_EN, b, m_dec, 1'b0));
        q.push_back(mk(K_WAIT, b, m_dec, 1'b0));
    endfunction

    function automatic void pop_cur();
        cur = q.pop_front();
        if (cur.kind == K_WAIT) wait_cnt = 1;
    endfunction

    always @(posedge clk) begin
        if (!n_rst) begin
            q.delete();
            m_blk  = '0;
            m_dec  = 1'b0;
            m_err  = 1'b0;
            cur    = mk(K_IDLE, '0, 1'b0, 1'b0);
            chk_en = 1;
        end else if (chk_en) begin
            if (cur.kind == K_WAIT) begin
                if (bus.enc_done) begin
                    for (int i = 0; i < BLK_WORDS; i++) q.push_back(mk(K_WR, m_blk, m_dec, 1'b0));
                    for (int i = 0; i < POST_WAIT_CYC; i++) q.push_back(mk(K_GAP, m_blk, m_dec, 1'b0));
                    if (int'(m_blk) == m_n - 1) begin
                        q.push_back(mk(K_IDLE, m_blk, m_dec, 1'b1));
                    end else begin
                        m_blk = m_blk + 1'b1;
                        sched_block(m_blk);
                    end
                    pop_cur();
                end else begin
`ifdef AES_BURST_CTRL_TIMEOUT_EN
                    if (wait_cnt >= TIMEOUT_CYC) begin
                        cur   = mk(K_IDLE, m_blk, m_dec, 1'b1);
                        m_err = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
`endif
                end
            end else if (cur.kind == K_CHG) begin
                if (bus.chg_key_done) cur = mk(K_IDLE, m_blk, m_dec, 1'b1);
            end else if (q.size() > 0) begin
                pop_cur();
            end else begin
                cur = mk(K_IDLE, m_blk, m_dec, 1'b0);
                if (bus.start) begin
                    m_err = 1'b0;
                    if (bus.change_key) begin
                        cur = mk(K_CHG, m_blk, m_dec, 1'b0);
                    end else if (bus.num_blocks == '0) begin
                        cur = mk(K_IDLE, m_blk, m_dec, 1'b1);
                    end else begin
                        m_n   = int'(bus.num_blocks);
                        m_dec = bus.decrypt;
                        m_blk = '0;
                        sched_block(m_blk);
                        pop_cur();
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and event counters ----------------
    int rd_n, wr_n, dn_n, en_n, gap_n, dec_bad, max_blk;
    outs_t act;

    always @(negedge clk) begin
        if (chk_en) begin
            act = {bus.restart_check, bus.busy, bus.change_key_start, bus.aes_enable,
                   bus.ahb_mode, bus.ahb_shift_en, bus.done, bus.aes_decrypt, bus.blk_idx};
            checks++;
            if (act !== cur.o) begin
                errors++;
                $display("FAIL outputs t=%0t got rc/busy/cks/en/mode/shift/done/dec=%b blk=%0d want %b blk=%0d",
                         $time, act[BCNT_W+7:BCNT_W], act.blk, cur.o[BCNT_W+7:BCNT_W], cur.o.blk);
            end
`ifdef AES_BURST_CTRL_TIMEOUT_EN
            checks++;
            if (bus.error !== m_err) begin
                errors++;
                $display("FAIL error_flag t=%0t got %b want %b", $time, bus.error, m_err);
            end
`endif
            if (bus.ahb_shift_en && !bus.ahb_mode) rd_n++;
            if (bus.ahb_shift_en && bus.ahb_mode) wr_n++;
            if (bus.done) dn_n++;
            if (bus.aes_enable) en_n++;
            if (bus.busy && !bus.ahb_shift_en && !bus.aes_enable && !bus.change_key_start) gap_n++;
            if (bus.busy && !bus.aes_decrypt) dec_bad++;
            if (int'(bus.blk_idx) > max_blk) max_blk = int'(bus.blk_idx);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clear_mon();
        #1;
        rd_n = 0; wr_n = 0; dn_n = 0; en_n = 0; gap_n = 0; dec_bad = 0; max_blk = 0;
    endtask

    task automatic pulse_start(input logic ck, input logic dc, input int n);
        bus.start      = 1'b1;
        bus.change_key = ck;
        bus.decrypt    = dc;
        bus.num_blocks = BCNT_W'(n);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.change_key = 1'b0;
        bus.decrypt    = 1'b0;
        bus.num_blocks = '0;
    endtask

    // Returns at the negedge of the first WAIT_AES cycle (enable seen PRE+1 times in a row)
    task automatic wait_aes_state();
        int run;
        bit ok;
        run = 0;
        ok  = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.aes_enable) run++;
            else run = 0;
            if (run >= PRE_WAIT_CYC + 1) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_aes_timeout got no WAIT_AES want WAIT_AES within 300 cycles");
        end
    endtask

    task automatic pulse_enc();
        bus.enc_done = 1'b1;
        @(negedge clk);
        bus.enc_done = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done want done within %0d cycles", bound);
        end
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.start        = 1'b0;
        bus.change_key   = 1'b0;
        bus.decrypt      = 1'b0;
        bus.num_blocks   = '0;
        bus.chg_key_done = 1'b0;
        bus.enc_done     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_restart_check", 32'(bus.restart_check), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_blk_idx", 32'(bus.blk_idx), 0);
        chk("rst_aes_decrypt", 32'(bus.aes_decrypt), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Key change
        pulse_start(1'b1, 1'b0, 0);
        chk("chg_key_start_on", 32'(bus.change_key_start), 1);
        chk("chg_busy", 32'(bus.busy), 1);
        repeat (3) @(negedge clk);
        bus.chg_key_done = 1'b1;
        @(negedge clk);
        bus.chg_key_done = 1'b0;
        chk("chg_done_pulse", 32'(bus.done), 1);
        chk("chg_busy_after", 32'(bus.busy), 0);
        @(negedge clk);
        chk("chg_done_cleared", 32'(bus.done), 0);

        // One-block encrypt, with a stray enc_done during INIT_WAIT
        clear_mon();
        pulse_start(1'b0, 1'b0, 1);
        repeat (5) @(negedge clk);
        pulse_enc();
        wait_aes_state();
        pulse_enc();
        wait_done(60);
        chk("b1_read_shifts", 32'(rd_n), 4);
        chk("b1_write_shifts", 32'(wr_n), 4);
        chk("b1_enable_cycles", 32'(en_n), 3);
        chk("b1_gap_cycles", 32'(gap_n), 17);
        chk("b1_done_pulses", 32'(dn_n), 1);

        // Three-block decrypt with an ignored mid-burst start
        clear_mon();
        pulse_start(1'b0, 1'b1, 3);
        for (int b = 0; b < 3; b++) begin
            wait_aes_state();
            pulse_enc();
            if (b == 0) pulse_start(1'b0, 1'b0, 5);
        end
        wait_done(80);
        chk("b3_read_shifts", 32'(rd_n), 12);
        chk("b3_write_shifts", 32'(wr_n), 12);
        chk("b3_enable_cycles", 32'(en_n), 9);
        chk("b3_gap_cycles", 32'(gap_n), 31);
        chk("b3_done_pulses", 32'(dn_n), 1);
        chk("b3_max_blk_idx", 32'(max_blk), 2);
        chk("b3_decrypt_drops", 32'(dec_bad), 0);

        // Zero-block command
        @(negedge clk);
        pulse_start(1'b0, 1'b0, 0);
        chk("zero_done_pulse", 32'(bus.done), 1);
        chk("zero_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("zero_done_cleared", 32'(bus.done), 0);

        // Reset during WAIT_AES of block 1
        pulse_start(1'b0, 1'b1, 3);
        wait_aes_state();
        pulse_enc();
        wait_aes_state();
        chk("abort_blk_before", 32'(bus.blk_idx), 1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk("abort_restart_check", 32'(bus.restart_check), 1);
        chk("abort_blk_idx", 32'(bus.blk_idx), 0);
        chk("abort_aes_decrypt", 32'(bus.aes_decrypt), 0);
        chk("abort_done", 32'(bus.done), 0);
        clear_mon();
        repeat (5) @(negedge clk);
        #1;
        chk("abort_no_done_later", 32'(dn_n), 0);

`ifdef AES_BURST_CTRL_TIMEOUT_EN
        // Watchdog: no enc_done
        clear_mon();
        pulse_start(1'b0, 1'b0, 1);
        wait_done(200);
        chk("tmo_error_set", 32'(bus.error), 1);
        chk("tmo_busy", 32'(bus.busy), 0);
        chk("tmo_enable_cycles", 32'(en_n), PRE_WAIT_CYC + TIMEOUT_CYC);
        @(negedge clk);
        chk("tmo_error_sticky", 32'(bus.error), 1);
        pulse_start(1'b0, 1'b0, 0);
        chk("tmo_error_cleared", 32'(bus.error), 0);
        chk("tmo_zero_done", 32'(bus.done), 1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/aes_burst_ctrl.md
Name: aes_burst_ctrl

Overview:
Parametrised next-generation AES datapath controller. It sequences key change, AHB-lite read/write word shifting, and AES core enable for a burst of N 128-bit blocks per start command. Block size in bus words, the three wait windows, and the encrypt/decrypt mode are configurable. It adds busy/done status, a block index, and an optional AES-done watchdog. It sits between the AHB-lite slave interface, GenKey/preAddKey, and AESctr.

Parameters:
BLK_WORDS, 4, bus words shifted per block on read and on write (1..16)
INIT_WAIT_CYC, 10, idle cycles after the first block read of a burst (>=1)
PRE_WAIT_CYC, 2, cycles aes_enable is held before each block's WAIT_AES (>=1)
POST_WAIT_CYC, 7, recovery cycles after each block write (>=1)
BCNT_W, 8, width of the block-count input and block index
TIMEOUT_CYC, 64, WAIT_AES watchdog limit (used only with the macro)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
start  in  1  one-cycle command strobe from the AHB interface
change_key  in  1  qualifies start: 1=key change, 0=data burst
decrypt  in  1  qualifies start: 0=encrypt, 1=decrypt; latched at start
num_blocks  in  BCNT_W  blocks in the burst; latched at start
chg_key_done  in  1  GenKey finished storing the key
enc_done  in  1  AESctr one-cycle pulse: block result ready
change_key_start  out  1  held high in CHG_KEY
aes_enable  out  1  AES core enable
aes_decrypt  out  1  latched mode to AESctr
ahb_mode  out  1  0=read from SRAM, 1=write to SRAM
ahb_shift_en  out  1  one bus word shifted per high cycle
restart_check  out  1  high in IDLE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes
blk_idx  out  BCNT_W  index of the block in progress, 0-based
error  out  1  sticky timeout flag (only with the macro)

Behaviour:
- Reset is synchronous: at a clk edge with n_rst=0, the state becomes IDLE and all counters clear. aes_decrypt, blk_idx, and error clear to 0. Other outputs follow IDLE decoding: restart_check=1, all other outputs 0.
- Reset mid-operation aborts the operation immediately. No done pulse is issued.
- All outputs except aes_decrypt, blk_idx, and error are Moore-decoded from the state register.
- One shared wait/word counter is cleared on every state entry. A timed state lasts exactly its parameter in cycles.
- IDLE:
  - start && change_key goes to CHG_KEY.
  - start && !change_key && num_blocks!=0 latches decrypt and num_blocks, clears blk_idx, and goes to READ.
  - start && num_blocks==0 stays in IDLE and pulses done on the next cycle.
  - start is ignored outside IDLE.
- CHG_KEY: change_key_start=1. On chg_key_done, go to IDLE and pulse done in the same cycle as the transition. CHG_KEY has no timeout.
- READ: ahb_mode=0, ahb_shift_en=1 for exactly BLK_WORDS cycles. Then go to INIT_WAIT if blk_idx==0, otherwise to PRE_WAIT.
- INIT_WAIT: all outputs low for INIT_WAIT_CYC cycles, then go to PRE_WAIT.
- PRE_WAIT: aes_enable=1 for PRE_WAIT_CYC cycles, then go to WAIT_AES.
- WAIT_AES: aes_enable=1. On enc_done, go to WRITE. An enc_done pulse outside WAIT_AES is ignored.
- WRITE: ahb_mode=1, ahb_shift_en=1, aes_enable=0 for exactly BLK_WORDS cycles, then go to POST_WAIT.
- POST_WAIT: outputs low for POST_WAIT_CYC cycles. On expiry:
  - if blk_idx==num_blocks_latched-1, go to IDLE with a done pulse;
  - otherwise increment blk_idx and go to READ.
- blk_idx wraps only by truncation. num_blocks is at most 2^BCNT_W-1, so no wrap occurs within a legal burst.
- Counter width is clog2(max(BLK_WORDS, INIT_WAIT_CYC, PRE_WAIT_CYC, POST_WAIT_CYC, TIMEOUT_CYC)+1).

Optional Feature:
AES_BURST_CTRL_TIMEOUT_EN:
- Defined: in WAIT_AES the counter runs. After TIMEOUT_CYC cycles without enc_done, the FSM goes to IDLE, sets error=1, and pulses done. error stays set until the next accepted start or reset. enc_done arriving on the same cycle as expiry wins, so no error is raised.
- Undefined: the error port is absent, TIMEOUT_CYC is unused, and WAIT_AES waits indefinitely.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum typedef (IDLE, CHG_KEY, READ, INIT_WAIT, PRE_WAIT, WAIT_AES, WRITE, POST_WAIT);
  - AHB_RD=1'b0 and AHB_WR=1'b1 constants;
  - a clog2-based counter-width function.
- One sub-module, aes_ctrl_timer: a clearable up-counter with a runtime terminal value and a terminal flag. It is instantiated once and shared by all timed states.

Test Plan:
- Reset, then start=1, change_key=1 -> change_key_start=1 from the next cycle. chg_key_done at cycle 5 -> IDLE, done pulse, busy=0.
- Defaults, num_blocks=1, decrypt=0 -> ahb_shift_en high 4 cycles with ahb_mode=0, then 10 idle cycles, then aes_enable high 2 cycles before WAIT_AES. enc_done -> 4 write shifts, then 7 cycles, then a done pulse.
- num_blocks=3, decrypt=1 -> aes_decrypt=1 throughout. blk_idx steps 0,1,2. INIT_WAIT occurs only once. Exactly 12 read and 12 write shifts. One done pulse.
- num_blocks=0 with start -> busy stays 0, done pulses one cycle later. start asserted mid-burst -> ignored.
- n_rst=0 during WAIT_AES of block 1 -> next edge gives IDLE, blk_idx=0, aes_decrypt=0, no done pulse.
- With AES_BURST_CTRL_TIMEOUT_EN and no enc_done for 64 cycles -> error=1, done pulse, IDLE. The next start clears error.
